// File: rtl/vic_pkg.sv
// vic_pkg: shared FSM encoding and bit-scan helpers for the vectored interrupt controller.
package vic_pkg;
   typedef enum logic {IDLE = 1'b0, REQ = 1'b1} vic_state_e;
   localparam int MAX_CH = 16;
   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
   function automatic logic [MAX_CH-1:0] lowest_set(input logic [MAX_CH-1:0] v);
      return v & (-v);
   endfunction
endpackage

// File: rtl/vic_prio_enc.sv
// vic_prio_enc: lowest-index-wins priority encoder producing valid, index and one-hot.
module vic_prio_enc
   import vic_pkg::*;
#(
   parameter int N = 8,
   parameter int W = ch_w(N)
) (
   input  logic [N-1:0] i_vec,
   output logic         o_valid,
   output logic [W-1:0] o_idx,
   output logic [N-1:0] o_onehot
);
   logic [MAX_CH-1:0] w_oh;
   assign w_oh     = lowest_set(MAX_CH'(i_vec));
   assign o_onehot = w_oh[N-1:0];
   assign o_valid  = |w_oh;
   always_comb begin
      o_idx = '0;
      for (int i = 0; i < MAX_CH; i++)
         if (w_oh[i]) o_idx = W'(i);
   end
endmodule

// File: rtl/vectored_int_ctrl.sv
// vectored_int_ctrl: N_CH-channel vectored priority interrupt controller with nesting.
// Define VIC_EDGE_TRIG_EN for edge-triggered requests; the default build is level-triggered.
module vectored_int_ctrl
   import vic_pkg::*;
#(
   parameter int               N_CH        = 8,
   parameter int               VEC_W       = 8,
   parameter logic [VEC_W-1:0] VEC_BASE    = 8'hF0,
   parameter int               VEC_STRIDE  = 2,
   parameter int               SYNC_STAGES = 2
) (
   input  logic                  g_clk,
   input  logic                  g_clr,
   input  logic [N_CH-1:0]       int_req,
   input  logic [N_CH-1:0]       int_mask,
   input  logic                  ien,
   input  logic                  int_ack,
   input  logic                  int_eoi,
   output logic                  i_pending,
   output logic [VEC_W-1:0]      int_vec,
   output logic [ch_w(N_CH)-1:0] int_ch,
   output logic [N_CH-1:0]       in_service
);
   localparam int CW = ch_w(N_CH);

   vic_state_e      r_state, w_next;
   logic [N_CH-1:0] w_req, w_set, r_pend, r_isr, r_gnt_oh;
   logic [N_CH-1:0] w_elig, w_elig_oh, w_isr_oh, w_allow, w_ack_oh;
   logic            w_elig_any, w_isr_any, w_ack, w_gnt_ok;
   logic [CW-1:0]   w_elig_idx, w_isr_idx, r_ch;
   logic [VEC_W-1:0] w_vec, r_vec;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign w_req = int_req;
      end else begin : g_sync
         logic [N_CH-1:0] r_sync [SYNC_STAGES];
         always_ff @(posedge g_clk or negedge g_clr)
            if (!g_clr) begin
               for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
            end else begin
               r_sync[0] <= int_req;
               for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            end
         assign w_req = r_sync[SYNC_STAGES-1];
      end
   endgenerate

   assign w_ack    = int_ack && (r_state == REQ);
   assign w_ack_oh = w_ack ? r_gnt_oh : '0;

`ifdef VIC_EDGE_TRIG_EN
   logic [N_CH-1:0] r_req_d;
   always_ff @(posedge g_clk or negedge g_clr)
      if (!g_clr) r_req_d <= '0;
      else        r_req_d <= w_req;
   assign w_set = w_req & ~r_req_d;
   // ack clears even a coincident new edge: a held request pends only once
   always_ff @(posedge g_clk or negedge g_clr)
      if (!g_clr) r_pend <= '0;
      else        r_pend <= (r_pend | w_set) & ~w_ack_oh;
`else
   assign w_set = w_req;
   // set wins over ack so a still-asserted level request re-pends
   always_ff @(posedge g_clk or negedge g_clr)
      if (!g_clr) r_pend <= '0;
      else        r_pend <= (r_pend & ~w_ack_oh) | w_set;
`endif

   vic_prio_enc #(.N(N_CH), .W(CW)) u_isr_enc (
      .i_vec   (r_isr),
      .o_valid (w_isr_any),
      .o_idx   (w_isr_idx),
      .o_onehot(w_isr_oh)
   );

   // only channels strictly above the highest in-service one may nest
   always_comb
      for (int i = 0; i < N_CH; i++) w_allow[i] = !w_isr_any || (CW'(i) < w_isr_idx);

   assign w_elig = r_pend & int_mask & {N_CH{ien}} & w_allow;

   vic_prio_enc #(.N(N_CH), .W(CW)) u_elig_enc (
      .i_vec   (w_elig),
      .o_valid (w_elig_any),
      .o_idx   (w_elig_idx),
      .o_onehot(w_elig_oh)
   );

   assign w_gnt_ok = |(w_elig & r_gnt_oh);
   assign w_vec    = VEC_BASE + VEC_W'(int'(w_elig_idx) * VEC_STRIDE);

   always_ff @(posedge g_clk or negedge g_clr)
      if (!g_clr) r_state <= IDLE;
      else        r_state <= w_next;

   always_comb
      w_next = (r_state == IDLE) ? (w_elig_any ? REQ : IDLE)
                                 : ((w_ack || !w_gnt_ok) ? IDLE : REQ);

   always_comb
      i_pending = (r_state == REQ);

   always_ff @(posedge g_clk or negedge g_clr)
      if (!g_clr) begin
         r_ch     <= '0;
         r_vec    <= VEC_BASE;
         r_gnt_oh <= '0;
      end else if (r_state == IDLE && w_elig_any) begin
         r_ch     <= w_elig_idx;
         r_vec    <= w_vec;
         r_gnt_oh <= w_elig_oh;
      end

   always_ff @(posedge g_clk or negedge g_clr)
      if (!g_clr) r_isr <= '0;
      else        r_isr <= (r_isr & ~(int_eoi ? w_isr_oh : '0)) | w_ack_oh;

   assign int_vec    = r_vec;
   assign int_ch     = r_ch;
   assign in_service = r_isr;
endmodule

// File: tb/tb_vectored_int_ctrl.sv
// tb_vectored_int_ctrl: scoreboard bench with a set-based reference model of the interrupt controller.
module tb_vectored_int_ctrl;
`ifdef VIC_EDGE_TRIG_EN
   localparam bit EDGE = 1'b1;
`else
   localparam bit EDGE = 1'b0;
`endif
   typedef struct {
      int         ch;
      logic [7:0] vec;
      logic [7:0] isr;
   } exp_t;

   logic       clk = 1'b0, g_clr = 1'b0, ien = 1'b1, int_ack = 1'b0, int_eoi = 1'b0;
   logic [7:0] int_req = 8'h00, int_mask = 8'hFF;
   logic       i_pending;
   logic [7:0] int_vec, in_service;
   logic [2:0] int_ch;

   int   n_chk = 0, n_fail = 0;
   exp_t sb[$];
   logic [7:0] m_pend = 8'h00, m_isr = 8'h00, m_mask = 8'hFF, m_held = 8'h00;
   logic m_ien = 1'b1, m_gnt = 1'b0;
   int   m_gch = 0;
   logic prev_pend = 1'b0;

   vectored_int_ctrl dut (
      .g_clk(clk), .g_clr(g_clr), .int_req(int_req), .int_mask(int_mask), .ien(ien),
      .int_ack(int_ack), .int_eoi(int_eoi), .i_pending(i_pending), .int_vec(int_vec),
      .int_ch(int_ch), .in_service(in_service)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endtask

   function automatic int lowest(input logic [7:0] v);
      for (int i = 0; i < 8; i++) if (v[i]) return i;
      return -1;
   endfunction

   // a channel is eligible if pending, enabled, and strictly more urgent than everything in service
   function automatic logic [7:0] elig();
      int h = lowest(m_isr);
      logic [7:0] e = 8'h00;
      for (int i = 0; i < 8; i++)
         if (m_pend[i] && m_mask[i] && m_ien && (h < 0 || i < h)) e[i] = 1'b1;
      return e;
   endfunction

   task automatic arbitrate();
      logic [7:0] e = elig();
      int c = lowest(e);
      if (m_gnt && !e[m_gch]) m_gnt = 1'b0;
      if (!m_gnt && c >= 0) begin
         m_gnt = 1'b1;
         m_gch = c;
         sb.push_back('{c, 8'(8'hF0 + 2 * c), m_isr});
      end
   endtask

   task automatic step();
      repeat (6) @(posedge clk);
      #1;
      chk("pending_level", 32'(i_pending), 32'(m_gnt));
      chk("in_service", 32'(in_service), 32'(m_isr));
   endtask

   task automatic pulse_req(input logic [7:0] r);
      int_req = r;
      m_pend |= r;
      arbitrate();
      @(posedge clk); #1;
      int_req = 8'h00;
      step();
   endtask

   task automatic set_mask(input logic [7:0] m);
      int_mask = m;
      m_mask = m;
      arbitrate();
      step();
   endtask

   task automatic set_ien(input logic v);
      ien = v;
      m_ien = v;
      arbitrate();
      step();
   endtask

   // eoi acts on the in-service set as it was before the edge, so apply it before the ack
   task automatic ctl(input logic a, input logic e);
      int h = lowest(m_isr);
      int_ack = a;
      int_eoi = e;
      if (e && h >= 0) m_isr[h] = 1'b0;
      if (a && m_gnt) begin
         m_pend[m_gch] = 1'b0;
         if (!EDGE) m_pend |= m_held;
         m_isr[m_gch] = 1'b1;
         m_gnt = 1'b0;
      end
      arbitrate();
      @(posedge clk); #1;
      int_ack = 1'b0;
      int_eoi = 1'b0;
      step();
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (i_pending && !prev_pend) begin
         if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL grant_unexpected: got ch %0d vec %0h, required no grant", int_ch, int_vec);
         end else begin
            e = sb.pop_front();
            chk("grant_ch", 32'(int_ch), 32'(e.ch));
            chk("grant_vec", 32'(int_vec), 32'(e.vec));
            chk("grant_isr", 32'(in_service), 32'(e.isr));
         end
      end
      prev_pend = i_pending;
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pending", 32'(i_pending), 32'(0));
      chk("rst_vec", 32'(int_vec), 32'(8'hF0));
      chk("rst_ch", 32'(int_ch), 32'(0));
      chk("rst_isr", 32'(in_service), 32'(0));
      g_clr = 1'b1;
      step();

      int_req = 8'h08;
      m_pend |= 8'h08;
      arbitrate();
      @(posedge clk); #1;
      int_req = 8'h00;
      repeat (2) @(posedge clk);
      #1 chk("latency_early", 32'(i_pending), 32'(0));
      @(posedge clk);
      #1 chk("latency_on", 32'(i_pending), 32'(1));
      step();
      ctl(1'b1, 1'b0);

      pulse_req(8'h20);
      pulse_req(8'h02);
      ctl(1'b1, 1'b0);
      ctl(1'b0, 1'b1);
      ctl(1'b0, 1'b1);
      ctl(1'b1, 1'b0);
      ctl(1'b0, 1'b1);

      pulse_req(8'h24);
      ctl(1'b1, 1'b0);
      ctl(1'b0, 1'b1);
      ctl(1'b1, 1'b1);
      ctl(1'b0, 1'b1);

      pulse_req(8'h10);
      int_mask = 8'hEF;
      m_mask = 8'hEF;
      arbitrate();
      @(posedge clk);
      #1 chk("withdraw", 32'(i_pending), 32'(0));
      step();
      set_mask(8'hFF);
      ctl(1'b1, 1'b0);
      ctl(1'b0, 1'b1);

      int_req = 8'h01;
      m_held = 8'h01;
      m_pend |= 8'h01;
      arbitrate();
      step();
      ctl(1'b1, 1'b0);
      ctl(1'b0, 1'b1);
      int_req = 8'h00;
      m_held = 8'h00;
      step();
      ctl(1'b1, 1'b1);
      ctl(1'b0, 1'b1);

      pulse_req(8'h20);
      ctl(1'b1, 1'b0);
      pulse_req(8'h08);
      g_clr = 1'b0;
      #1;
      chk("rst_mid_pending", 32'(i_pending), 32'(0));
      chk("rst_mid_isr", 32'(in_service), 32'(0));
      chk("rst_mid_vec", 32'(int_vec), 32'(8'hF0));
      chk("rst_mid_sb", 32'(sb.size()), 32'(0));
      m_pend = 8'h00;
      m_isr = 8'h00;
      m_gnt = 1'b0;
      @(posedge clk); #1;
      g_clr = 1'b1;
      step();

      for (int k = 0; k < 200; k++) begin
         case ($urandom_range(0, 6))
            0, 1: pulse_req(8'($urandom_range(0, 255) & $urandom_range(0, 255)));
            2: set_mask(8'($urandom_range(0, 255) | $urandom_range(0, 255)));
            3: set_ien($urandom_range(0, 3) != 0);
            4: ctl(1'b1, 1'b0);
            5: ctl(1'b0, 1'b1);
            default: ctl(1'b1, 1'b1);
         endcase
      end
      chk("sb_drained", 32'(sb.size()), 32'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
